// File: rtl/led_breath.sv
// LED driver with OFF / ON / BLINK / BREATHE modes. Breathing ramps a PWM duty
// up and down on upstream ticks, with dwell periods at full and zero brightness.
module led_breath #(
   parameter int unsigned PWM_BITS    = 8,
   parameter int unsigned STEP_TICKS  = 20,
   parameter int unsigned HOLD_TICKS  = 2000,
   parameter int unsigned BLINK_TICKS = 5000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tick,
   input  logic [1:0]          mode,
   output logic                led,
   output logic [PWM_BITS-1:0] duty,
   output logic [2:0]          phase
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RAMP_UP = 3'd1,
      HOLD_HI = 3'd2,
      RAMP_DN = 3'd3,
      HOLD_LO = 3'd4
   } phase_t;

   localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
   localparam logic [PWM_BITS-1:0] DUTY_TOP   = DUTY_MAX - 1'b1;
   localparam logic [PWM_BITS-1:0] DUTY_ONE   = {{(PWM_BITS-1){1'b0}}, 1'b1};
   localparam logic [15:0]         STEP_LAST  = 16'(STEP_TICKS - 1);
   localparam logic [15:0]         HOLD_LAST  = 16'(HOLD_TICKS - 1);
   localparam logic [15:0]         BLINK_LAST = 16'(BLINK_TICKS - 1);

   logic [PWM_BITS-1:0] pwm_cnt;
   mode_t               mode_q;
   logic [15:0]         tick_cnt, tick_cnt_nx;
   logic [PWM_BITS-1:0] duty_nx;
   logic                blink_lvl, blink_nx;
   phase_t              state, state_nx;
   logic                led_nx;
   logic                mode_chg;

   assign mode_chg = (mode != mode_q);
   assign phase    = state;

   // NOTE: registers use non-blocking assignments so every flop samples
   // pre-edge values and simulation ordering between processes cannot matter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt   <= '0;
         mode_q    <= MODE_OFF;
         tick_cnt  <= '0;
         duty      <= '0;
         blink_lvl <= 1'b0;
         state     <= IDLE;
         led       <= 1'b0;
      end else begin
         pwm_cnt   <= pwm_cnt + 1'b1;
         mode_q    <= mode_t'(mode);
         tick_cnt  <= tick_cnt_nx;
         duty      <= duty_nx;
         blink_lvl <= blink_nx;
         state     <= state_nx;
         led       <= led_nx;
      end
   end

   // NOTE: every signal written here gets a default first, otherwise any path
   // that skips an assignment would infer a latch.
   always_comb begin
      state_nx    = state;
      tick_cnt_nx = tick_cnt;
      duty_nx     = duty;
      blink_nx    = blink_lvl;

      if (mode_chg) begin
         // A mode change wins over a coincident tick, which is dropped.
         tick_cnt_nx = '0;
         duty_nx     = '0;
         blink_nx    = 1'b0;
         state_nx    = (mode_t'(mode) == MODE_BREATHE) ? RAMP_UP : IDLE;
      end else if (tick) begin
         case (mode_q)
            MODE_BLINK: begin
               if (tick_cnt == BLINK_LAST) begin
                  tick_cnt_nx = '0;
                  blink_nx    = ~blink_lvl;
               end else begin
                  tick_cnt_nx = tick_cnt + 16'd1;
               end
            end
            MODE_BREATHE: begin
               case (state)
                  RAMP_UP: begin
                     if (tick_cnt == STEP_LAST) begin
                        tick_cnt_nx = '0;
                        if (duty >= DUTY_TOP) begin
                           duty_nx  = DUTY_MAX;
                           state_nx = HOLD_HI;
                        end else begin
                           duty_nx = duty + 1'b1;
                        end
                     end else begin
                        tick_cnt_nx = tick_cnt + 16'd1;
                     end
                  end
                  HOLD_HI: begin
                     if (tick_cnt == HOLD_LAST) begin
                        tick_cnt_nx = '0;
                        state_nx    = RAMP_DN;
                     end else begin
                        tick_cnt_nx = tick_cnt + 16'd1;
                     end
                  end
                  RAMP_DN: begin
                     if (tick_cnt == STEP_LAST) begin
                        tick_cnt_nx = '0;
                        if (duty <= DUTY_ONE) begin
                           duty_nx  = '0;
                           state_nx = HOLD_LO;
                        end else begin
                           duty_nx = duty - 1'b1;
                        end
                     end else begin
                        tick_cnt_nx = tick_cnt + 16'd1;
                     end
                  end
                  HOLD_LO: begin
                     if (tick_cnt == HOLD_LAST) begin
                        tick_cnt_nx = '0;
                        state_nx    = RAMP_UP;
                     end else begin
                        tick_cnt_nx = tick_cnt + 16'd1;
                     end
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   // LED follows the registered mode, so it reacts one edge after mode_q updates.
   always_comb begin
      led_nx = 1'b0;
      case (mode_q)
         MODE_OFF:     led_nx = 1'b0;
         MODE_ON:      led_nx = 1'b1;
         MODE_BLINK:   led_nx = blink_lvl;
         MODE_BREATHE: led_nx = (pwm_cnt < duty);
         default:      led_nx = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_led_breath.sv
// Bench for led_breath: closed-form model of brightness versus ticks since the
// last mode change, compared every cycle, plus hand-computed directed checks.
module tb_led_breath;

   localparam int PWM_BITS = 4;
   localparam int STEP     = 2;
   localparam int HOLD     = 3;
   localparam int BLINK    = 4;
   localparam int MAXV     = (1 << PWM_BITS) - 1;
   localparam int RAMP     = MAXV * STEP;
   localparam int PERIOD   = 2 * RAMP + 2 * HOLD;

   logic                clk;
   logic                rst_n;
   logic                tick;
   logic [1:0]          mode;
   logic                led;
   logic [PWM_BITS-1:0] duty;
   logic [2:0]          phase;

   int n_checks = 0;
   int n_pass   = 0;
   bit run_chk  = 1'b0;

   led_breath #(
      .PWM_BITS   (PWM_BITS),
      .STEP_TICKS (STEP),
      .HOLD_TICKS (HOLD),
      .BLINK_TICKS(BLINK)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .mode  (mode),
      .led   (led),
      .duty  (duty),
      .phase (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Model: mode as seen by the block, ticks counted since the last mode change,
   // free-running PWM phase and the registered LED value.
   int m_mode = 0;
   int m_k    = 0;
   int m_pwm  = 0;
   int m_led  = 0;

   function automatic int exp_phase();
      int p;
      if (m_mode != 3) return 0;
      p = m_k % PERIOD;
      if (p < RAMP)            return 1;
      if (p < RAMP + HOLD)     return 2;
      if (p < 2 * RAMP + HOLD) return 3;
      return 4;
   endfunction

   function automatic int exp_duty();
      int p;
      if (m_mode != 3) return 0;
      p = m_k % PERIOD;
      if (p < RAMP)            return p / STEP;
      if (p < RAMP + HOLD)     return MAXV;
      if (p < 2 * RAMP + HOLD) return MAXV - (p - RAMP - HOLD) / STEP;
      return 0;
   endfunction

   function automatic int exp_led_next();
      case (m_mode)
         1:       return 1;
         2:       return (m_k / BLINK) % 2;
         3:       return (m_pwm < exp_duty()) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0;
         m_k    = 0;
         m_pwm  = 0;
         m_led  = 0;
      end else begin
         m_led = exp_led_next();
         m_pwm = (m_pwm + 1) % (MAXV + 1);
         if (int'(mode) != m_mode) begin
            m_mode = int'(mode);
            m_k    = 0;
         end else if (tick) begin
            m_k++;
         end
      end
   end

   always @(negedge clk) begin
      if (run_chk && rst_n) begin
         check("model_led",   32'(led),   32'(m_led));
         check("model_duty",  32'(duty),  32'(exp_duty()));
         check("model_phase", 32'(phase), 32'(exp_phase()));
      end
   end

   task automatic do_tick();
      repeat (9) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic count_high(input int clks, output int n);
      n = 0;
      for (int i = 0; i < clks; i++) begin
         @(negedge clk);
         if (led === 1'b1) n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_high;
      int toggles;
      int first_rise;
      logic prev;

      rst_n = 1'b1;
      mode  = 2'd0;
      tick  = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_led",   32'(led),   32'd0);
      check("reset_duty",  32'(duty),  32'd0);
      check("reset_phase", 32'(phase), 32'd0);
      rst_n   = 1'b1;
      run_chk = 1'b1;
      @(negedge clk);

      // ON then OFF: LED follows two edges after the input changes.
      mode = 2'd1;
      @(negedge clk);
      check("on_led_1clk", 32'(led), 32'd0);
      @(negedge clk);
      check("on_led_2clk", 32'(led), 32'd1);
      mode = 2'd0;
      @(negedge clk);
      check("off_led_1clk", 32'(led), 32'd1);
      @(negedge clk);
      check("off_led_2clk", 32'(led), 32'd0);

      // BLINK for 100 ticks.
      mode       = 2'd2;
      prev       = led;
      toggles    = 0;
      first_rise = -1;
      for (int c = 0; c < 1002; c++) begin
         @(negedge clk);
         if (led !== prev) toggles++;
         if (led === 1'b1 && first_rise < 0) first_rise = c;
         prev = led;
         tick = (c % 10 == 9 && c < 1000);
      end
      check("blink_toggles",    32'(toggles),    32'd25);
      check("blink_first_rise", 32'(first_rise), 32'd41);

      // BREATHE over one full period.
      mode = 2'd3;
      for (int t = 1; t <= PERIOD; t++) begin
         do_tick();
         if (t == 16) begin
            check("br_duty_t16", 32'(duty), 32'd8);
            count_high(16, n_high);
            check("br_pwm_half", 32'(n_high), 32'd8);
         end
         if (t == 30) begin
            check("br_duty_t30",  32'(duty),  32'd15);
            check("br_phase_t30", 32'(phase), 32'd2);
         end
         if (t == 31) begin
            count_high(16, n_high);
            check("br_pwm_max", 32'(n_high), 32'd15);
         end
         if (t == 33) check("br_phase_t33", 32'(phase), 32'd3);
         if (t == 63) begin
            check("br_duty_t63",  32'(duty),  32'd0);
            check("br_phase_t63", 32'(phase), 32'd4);
         end
         if (t == 65) check("br_phase_t65", 32'(phase), 32'd4);
      end
      check("br_phase_t66", 32'(phase), 32'd1);
      check("br_duty_t66",  32'(duty),  32'd0);

      // Switch to BLINK at duty 9 on a tick clock: the tick is dropped.
      repeat (18) do_tick();
      check("sw_duty_before", 32'(duty), 32'd9);
      repeat (9) @(negedge clk);
      tick = 1'b1;
      mode = 2'd2;
      @(negedge clk);
      tick = 1'b0;
      check("sw_duty",  32'(duty),  32'd0);
      check("sw_phase", 32'(phase), 32'd0);
      repeat (4) do_tick();
      check("sw_led_before", 32'(led), 32'd0);
      @(negedge clk);
      check("sw_led_after", 32'(led), 32'd1);

      // Tick held high for 3 clocks counts as 3 ticks.
      mode = 2'd3;
      @(negedge clk);
      tick = 1'b1;
      repeat (3) @(negedge clk);
      tick = 1'b0;
      check("hold_tick_duty",  32'(duty),  32'd1);
      check("hold_tick_phase", 32'(phase), 32'd1);
      do_tick();
      check("hold_tick_duty2", 32'(duty), 32'd2);

      // Asynchronous reset in RAMP_DN at duty 5.
      mode = 2'd0;
      @(negedge clk);
      mode = 2'd3;
      @(negedge clk);
      repeat (53) do_tick();
      check("rd_duty",  32'(duty),  32'd5);
      check("rd_phase", 32'(phase), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("async_led",   32'(led),   32'd0);
      check("async_duty",  32'(duty),  32'd0);
      check("async_phase", 32'(phase), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_phase", 32'(phase), 32'd1);
      check("rel_duty",  32'(duty),  32'd0);
      repeat (2) do_tick();
      check("rel_duty2", 32'(duty), 32'd1);

      repeat (3) @(negedge clk);
      run_chk = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
